// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: core op codes, status bit
// positions and the serial FSM state encoding used by both directions.
package uart_pkg;

    localparam logic [1:0] UART_STATUS = 2'd0;
    localparam logic [1:0] UART_SEND   = 2'd1;
    localparam logic [1:0] UART_RECV   = 2'd2;
    localparam logic [1:0] UART_CLEAR  = 2'd3;

    localparam int ST_RX_AVAIL    = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_DONE     = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_FRAME_ERR   = 4;
    localparam int ST_TX_OVERFLOW = 5;

    typedef logic [1:0] ser_state_t;

    localparam ser_state_t SER_IDLE  = 2'd0;
    localparam ser_state_t SER_START = 2'd1;
    localparam ser_state_t SER_DATA  = 2'd2;
    localparam ser_state_t SER_STOP  = 2'd3;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push on a full FIFO is accepted
// only when a pop happens in the same cycle, and flush overrides everything.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX/RX FIFOs decouple the core from line timing and
// data_out is a zero-latency combinational read of registered state.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  uart_op,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        rx,
    output logic        tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic is_send, is_recv, is_clear;
    logic unused_data;

    logic [7:0] tx_head, rx_head;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_pop, rx_push;

    ser_state_t       tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shift;

    ser_state_t       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic             rx_wait;
    logic             rx_meta, rx_sync;
    logic             frame_err_set;

    logic        rx_overrun, frame_err, tx_overflow;
    logic [31:0] status_word;

    assign is_send     = (uart_op == UART_SEND);
    assign is_recv     = (uart_op == UART_RECV);
    assign is_clear    = (uart_op == UART_CLEAR);
    assign unused_data = ^data_in[31:8];

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (is_send),
        .push_data (data_in[7:0]),
        .pop       (tx_pop),
        .flush     (1'b0),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (is_recv),
        .flush     (is_clear),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // The transmitter reloads straight from STOP so back-to-back frames have no idle gap.
    assign tx_pop = !tx_empty &&
                    ((tx_state == SER_IDLE) || ((tx_state == SER_STOP) && (tx_cnt == BIT_LAST)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= SER_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                SER_IDLE: begin
                    if (tx_pop) begin
                        tx_shift <= tx_head;
                        tx_cnt   <= '0;
                        tx       <= 1'b0;
                        tx_state <= SER_START;
                    end
                end
                SER_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= SER_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                SER_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= SER_STOP;
                        end else begin
                            tx_idx <= tx_idx + 3'd1;
                            tx     <= tx_shift[tx_idx + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                SER_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_pop) begin
                            tx_shift <= tx_head;
                            tx       <= 1'b0;
                            tx_state <= SER_START;
                        end else begin
                            tx_state <= SER_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: tx_state <= SER_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_push       = (rx_state == SER_STOP) && !rx_wait && (rx_cnt == BIT_LAST) && rx_sync;
    assign frame_err_set = (rx_state == SER_STOP) && !rx_wait && (rx_cnt == BIT_LAST) && !rx_sync;

    // After a bad stop bit the receiver parks in STOP until the line returns high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= SER_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_wait  <= 1'b0;
        end else begin
            case (rx_state)
                SER_IDLE: begin
                    if (!rx_sync) begin
                        rx_cnt   <= '0;
                        rx_state <= SER_START;
                    end
                end
                SER_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_sync ? SER_IDLE : SER_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                SER_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt           <= '0;
                        rx_shift[rx_idx] <= rx_sync;
                        if (rx_idx == 3'd7)
                            rx_state <= SER_STOP;
                        else
                            rx_idx <= rx_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                SER_STOP: begin
                    if (rx_wait) begin
                        if (rx_sync) begin
                            rx_wait  <= 1'b0;
                            rx_state <= SER_IDLE;
                        end
                    end else if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_sync)
                            rx_state <= SER_IDLE;
                        else
                            rx_wait <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= SER_IDLE;
            endcase
        end
    end

    // CLEAR takes priority over any flag being raised in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            tx_overflow <= 1'b0;
        end else if (is_clear) begin
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (rx_push && rx_full && !is_recv)
                rx_overrun <= 1'b1;
            if (frame_err_set)
                frame_err <= 1'b1;
            if (is_send && tx_full && !tx_pop)
                tx_overflow <= 1'b1;
        end
    end

    always_comb begin
        status_word                 = '0;
        status_word[ST_RX_AVAIL]    = !rx_empty;
        status_word[ST_TX_FULL]     = tx_full;
        status_word[ST_TX_DONE]     = tx_empty && (tx_state == SER_IDLE);
        status_word[ST_RX_OVERRUN]  = rx_overrun;
        status_word[ST_FRAME_ERR]   = frame_err;
        status_word[ST_TX_OVERFLOW] = tx_overflow;
    end

    always_comb begin
        data_out = '0;
        case (uart_op)
            UART_STATUS: data_out = status_word;
            UART_RECV:   data_out = {23'b0, !rx_empty, (rx_empty ? 8'h00 : rx_head)};
            default:     data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: expected bytes are queued when stimulus is
// driven and popped when the DUT delivers them on RECV or on the tx line.
module tb_uart_mmio;
    import uart_pkg::*;

    localparam int CPB   = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  uart_op;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        rx;
    logic        tx;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    logic [31:0] rd;

    uart_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_op  (uart_op),
        .data_in  (data_in),
        .data_out (data_out),
        .rx       (rx),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 32'h%08h, expected 32'h%08h", tag, actual, expected);
        end
    endtask

    // Drive one op for exactly one clock and capture the same-cycle read value.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] din, output logic [31:0] rdata);
        @(negedge clk);
        uart_op = op;
        data_in = din;
        #1 rdata = data_out;
        @(posedge clk);
        #1;
        uart_op = UART_STATUS;
        data_in = '0;
    endtask

    task automatic checkStatus(input string tag, input logic [31:0] expected);
        logic [31:0] r;
        applyStimulus(UART_STATUS, 32'h0, r);
        checkOutput(tag, r, expected);
    endtask

    task automatic recvPop(input string tag);
        logic [31:0] r;
        logic [31:0] expected;
        applyStimulus(UART_RECV, 32'h0, r);
        if (rx_q.size() > 0)
            expected = {23'b0, 1'b1, rx_q.pop_front()};
        else
            expected = 32'h0;
        checkOutput(tag, r, expected);
    endtask

    task automatic serialSend(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic recvTxFrame(output logic [7:0] b, output int start_cyc);
        int budget;
        budget = 0;
        b = 8'h00;
        start_cyc = -1;
        @(negedge clk);
        while (tx !== 1'b0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (tx !== 1'b0) begin
            checkOutput("tx_start_timeout", {31'b0, tx}, 32'h0);
            return;
        end
        start_cyc = cyc;
        repeat (CPB / 2) @(negedge clk);
        checkOutput("tx_start_bit", {31'b0, tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        checkOutput("tx_stop_bit", {31'b0, tx}, 32'h1);
    endtask

    initial begin
        logic [9:0] fr;

        rst     = 1'b1;
        rx      = 1'b1;
        uart_op = UART_STATUS;
        data_in = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx_in_reset", {31'b0, tx}, 32'h1);
        rst = 1'b0;
        checkStatus("reset_status", 32'h4);
        checkOutput("reset_tx", {31'b0, tx}, 32'h1);

        // Single SEND: tx stays high until the edge after the write, then the exact waveform.
        applyStimulus(UART_SEND, 32'hFFFF_FFA5, rd);
        checkOutput("send_dout", rd, 32'h0);
        @(negedge clk);
        checkOutput("tx_high_before_load", {31'b0, tx}, 32'h1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                checkOutput("tx_a5_wave", {31'b0, tx}, {31'b0, fr[b]});
            end
        end
        repeat (2) @(negedge clk);
        checkStatus("status_after_tx", 32'h4);

        // Single received byte, then RECV on an empty FIFO.
        rx_q.push_back(8'h3C);
        serialSend(8'h3C, 1'b1);
        checkStatus("status_rx_avail", 32'h5);
        recvPop("recv_3c");
        recvPop("recv_empty");
        checkStatus("status_after_recv", 32'h4);

        // Overrun: one more frame than the RX FIFO holds.
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH)
                rx_q.push_back(8'(8'h40 + i));
            serialSend(8'(8'h40 + i), 1'b1);
        end
        checkStatus("status_overrun", 32'hD);
        recvPop("recv_after_overrun_0");
        recvPop("recv_after_overrun_1");
        checkStatus("status_overrun_sticky", 32'hD);
        applyStimulus(UART_CLEAR, 32'h0, rd);
        checkOutput("clear_dout", rd, 32'h0);
        rx_q.delete();
        checkStatus("status_after_clear", 32'h4);
        recvPop("recv_after_clear");

        // Framing error, then a short glitch that must be rejected.
        serialSend(8'h55, 1'b0);
        checkStatus("status_frame_err", 32'h14);
        recvPop("recv_after_frame_err");
        applyStimulus(UART_CLEAR, 32'h0, rd);
        checkStatus("status_frame_err_cleared", 32'h4);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkStatus("status_after_glitch", 32'h4);
        recvPop("recv_after_glitch");

        // Burst of SENDs while busy: overflow flag plus gapless back-to-back frames.
        fork
            begin
                logic [31:0] r;
                applyStimulus(UART_SEND, 32'h11, r);
                tx_q.push_back(8'h11);
                for (int i = 0; i < DEPTH + 1; i++) begin
                    applyStimulus(UART_SEND, 32'(8'h20 + i), r);
                    if (i < DEPTH)
                        tx_q.push_back(8'(8'h20 + i));
                end
                checkStatus("status_tx_full_overflow", 32'h22);
            end
            begin
                logic [7:0] b;
                int         st;
                int         prev;
                prev = -1;
                for (int k = 0; k < DEPTH + 1; k++) begin
                    recvTxFrame(b, st);
                    if (tx_q.size() > 0)
                        checkOutput("tx_frame_byte", {24'b0, b}, {24'b0, tx_q.pop_front()});
                    else
                        checkOutput("tx_frame_unexpected", {24'b0, b}, 32'hFFFF_FFFF);
                    if (k > 0)
                        checkOutput("tx_back_to_back_gap", 32'(st - prev), 32'(10 * CPB));
                    prev = st;
                end
            end
        join
        repeat (2 * CPB) @(negedge clk);
        checkStatus("status_after_burst", 32'h24);

        // Reset in the middle of a frame must release tx immediately.
        applyStimulus(UART_SEND, 32'h00, rd);
        repeat (3 * CPB) @(negedge clk);
        checkOutput("tx_midframe_low", {31'b0, tx}, 32'h0);
        #2 rst = 1'b1;
        #1 checkOutput("tx_async_reset", {31'b0, tx}, 32'h1);
        tx_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkStatus("status_after_midframe_reset", 32'h4);
        repeat (2 * CPB) @(negedge clk);
        checkOutput("tx_idle_after_reset", {31'b0, tx}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART peripheral that sits directly downstream of the core's memory-interaction stage.
- Consumes the core's 2-bit UART operation code and 32-bit store data.
- Returns a 32-bit read value in the same cycle, which the core writes to its register file.
- Contains a TX FIFO, an RX FIFO, and 8N1 serial transmitter and receiver, so the core never stalls on line timing.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); minimum 4
FIFO_DEPTH, 16, entries per FIFO; power of two, minimum 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
uart_op  input  2  operation from core, valid for exactly one cycle per access: 0 STATUS, 1 SEND, 2 RECV, 3 CLEAR
data_in  input  32  store data from core; bits [7:0] used by SEND
data_out  output  32  read value; combinational from current state, sampled by core at the same edge
rx  input  1  serial line in, asynchronous to clk
tx  output  1  serial line out, idle high

Behaviour:
- Clock and reset: single clock domain; rst asynchronous, active-high.
- Reset values:
  - tx=1, data_out=0 status-equivalent (FIFOs empty, flags clear).
  - Both FIFOs empty; transmitter and receiver in IDLE; sticky flags 0.
  - rx synchronizer flops preset to 1.
- Op 0 STATUS (non-editing, mandatory: no state change), data_out bit map:
  - [0] rx_avail, RX FIFO non-empty.
  - [1] tx_full.
  - [2] tx_done: TX FIFO empty and transmitter IDLE.
  - [3] rx_overrun, sticky.
  - [4] frame_err, sticky.
  - [5] tx_overflow, sticky.
  - [31:6] = 0.
- Op 1 SEND:
  - data_in[7:0] pushed into TX FIFO at the clock edge.
  - If FIFO full, byte dropped and tx_overflow set.
  - data_out = 0 (core discards it).
- Op 2 RECV:
  - data_out = {23'b0, rx_avail, rx_head[7:0]}; rx_head reads 0 when empty.
  - Pop at the same edge only if non-empty; empty RECV changes nothing.
- Op 3 CLEAR:
  - Flushes RX FIFO and clears all three sticky flags.
  - Does not affect TX FIFO or a frame in flight.
  - data_out = 0.
- data_out for ops 0 and 2 is purely combinational from registered state (zero-latency read).
- Transmitter FSM (IDLE, START, DATA, STOP):
  - IDLE→START when TX FIFO non-empty; pop at that edge.
  - Each bit lasts CLKS_PER_BIT cycles; DATA sends 8 bits LSB first using a 3-bit index.
  - STOP ends → START directly if FIFO non-empty (back-to-back, no idle gap), else IDLE.
  - From a SEND at edge E into an empty, idle unit: FIFO write at E, FSM load at E+1, tx low from E+1 onward.
- Receiver FSM (IDLE, START, DATA, STOP):
  - rx passes a 2-flop synchronizer first.
  - IDLE→START on synchronized low.
  - START waits CLKS_PER_BIT/2 and re-samples: still low → DATA; high → IDLE (glitch rejected).
  - DATA samples every CLKS_PER_BIT, 8 bits LSB first.
  - STOP samples one more bit period:
    - 1 → push byte; if RX FIFO full, byte dropped and rx_overrun set.
    - 0 → byte discarded, frame_err set, FSM waits for rx high before IDLE.
- Simultaneous events:
  - RX push and RECV pop in the same cycle on a full FIFO: both succeed, no overrun.
  - SEND while the transmitter pops the last entry: both succeed.
  - CLEAR coincident with a receiver push: CLEAR wins; FIFO ends empty and the flag is cleared.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits, wrapping naturally; full/empty decided by MSB comparison.
- rst asserted mid-frame: tx returns high immediately (asynchronously); partial RX byte is lost.

Decomposition:
- Shared package uart_pkg holds:
  - Op codes UART_STATUS=0, UART_SEND=1, UART_RECV=2, UART_CLEAR=3.
  - Status bit indices.
  - Serial FSM state enum.
- One natural sub-module: uart_fifo, parameterised on width and depth, providing push, pop, head, full, empty and flush. It is instantiated twice.
- TX and RX FSMs stay inline.

Test Plan:
- Reset, then STATUS → data_out=32'h4; tx=1 throughout.
- CLKS_PER_BIT=8, SEND 8'hA5 → tx low from the edge after the write; line shows 0,1,0,1,0,0,1,0,1,1 per 8 cycles; STATUS afterwards =32'h4.
- Drive serial 8'h3C on rx → STATUS=32'h5; RECV returns 32'h13C; second RECV returns 32'h0 and no flag changes.
- Fill RX with FIFO_DEPTH+1 frames → rx_overrun set (STATUS bit3). CLEAR → STATUS=32'h4 and RX empty.
- Frame with stop bit 0 → frame_err set, no push. A 2-cycle low glitch on rx → ignored, no flags set.
- 17 back-to-back SENDs with depth 16 and tx busy → tx_overflow set; 16 frames emitted with no idle gap between stop and start bits; assert rst mid-frame → tx=1 immediately, STATUS=32'h4 after reset.
